// File: rtl/aclk_pkg.sv
// Shared types and limits for the alarm-clock keypad entry path.
// Digit limits describe the largest legal HH:MM value, 23:59.
package aclk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ENTRY    = 2'd1,
    ST_COMMIT_A = 2'd2,
    ST_COMMIT_C = 2'd3
  } state_e;

  localparam logic [3:0] KEY_MAX_DIGIT      = 4'd9;
  localparam logic [3:0] MAX_HR_TENS        = 4'd2;
  localparam logic [3:0] MAX_HR_UNITS_AT_20 = 4'd3;
  localparam logic [3:0] MAX_MIN_TENS       = 4'd5;
  localparam int unsigned NUM_DIGITS        = 4;
  localparam logic [2:0] CNT_FULL           = 3'(NUM_DIGITS);

endpackage

// File: rtl/aclk_key_shreg.sv
// Four-digit HH:MM entry buffer with a saturating count of accepted digits.
// load_i restarts the buffer with a single digit; shift_i appends one.
module aclk_key_shreg
  import aclk_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic       shift_i,
  input  logic       cnt_clr_i,
  input  logic [3:0] key_i,
  output logic [3:0] ms_hr_o,
  output logic [3:0] ls_hr_o,
  output logic [3:0] ms_min_o,
  output logic [3:0] ls_min_o,
  output logic [2:0] count_o
);

  logic [3:0] ms_hr_q, ls_hr_q, ms_min_q, ls_min_q;
  logic [2:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_hr_q  <= 4'd0;
      ls_hr_q  <= 4'd0;
      ms_min_q <= 4'd0;
      ls_min_q <= 4'd0;
      count_q  <= 3'd0;
    end else if (load_i) begin
      ms_hr_q  <= 4'd0;
      ls_hr_q  <= 4'd0;
      ms_min_q <= 4'd0;
      ls_min_q <= key_i;
      count_q  <= 3'd1;
    end else if (shift_i) begin
      ms_hr_q  <= ls_hr_q;
      ls_hr_q  <= ms_min_q;
      ms_min_q <= ls_min_q;
      ls_min_q <= key_i;
      if (count_q < CNT_FULL) count_q <= count_q + 3'd1;
    end else if (cnt_clr_i) begin
      // Buffer is left untouched so the last entry stays on the digit bus.
      count_q <= 3'd0;
    end
  end

  assign ms_hr_o  = ms_hr_q;
  assign ls_hr_o  = ls_hr_q;
  assign ms_min_o = ms_min_q;
  assign ls_min_o = ls_min_q;
  assign count_o  = count_q;

endmodule

// File: rtl/aclk_key_entry.sv
// Keypad entry controller: collects HH:MM digits, validates them and issues
// one-cycle load strobes to the alarm register or the time counter.
//
//   state       | meaning
//   ST_IDLE     | waiting for a first digit, buffer held on the bus
//   ST_ENTRY    | collecting digits, watching buttons and inactivity timer
//   ST_COMMIT_A | valid value accepted for the alarm register
//   ST_COMMIT_C | valid value accepted for the time counter
module aclk_key_entry
  import aclk_pkg::*;
#(
  parameter int TIMEOUT_SEC = 10,
  parameter int TMR_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       key_valid,
  input  logic       alarm_button,
  input  logic       time_button,
  output logic [3:0] new_alarm_ms_hr,
  output logic [3:0] new_alarm_ls_hr,
  output logic [3:0] new_alarm_ms_min,
  output logic [3:0] new_alarm_ls_min,
  output logic       load_new_a,
  output logic       load_new_c,
  output logic       show_new_time,
  output logic [2:0] digit_count
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_SEC - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             alarm_d_q, time_d_q;
  logic             load_a_q, load_c_q, show_q;

  logic       alarm_edge, time_edge, digit_ok, value_ok;
  logic       sh_load, sh_shift, cnt_clr;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic [2:0] count;

  assign alarm_edge = alarm_button & ~alarm_d_q;
  assign time_edge  = time_button & ~time_d_q;
  assign digit_ok   = key_valid && (key <= KEY_MAX_DIGIT);

  always_comb begin
    value_ok = (count == CNT_FULL) && (ms_hr <= MAX_HR_TENS) && (ms_min <= MAX_MIN_TENS);
    if (ms_hr == MAX_HR_TENS) value_ok = value_ok && (ls_hr <= MAX_HR_UNITS_AT_20);
    else                      value_ok = value_ok && (ls_hr <= KEY_MAX_DIGIT);
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    cnt_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (digit_ok) begin
          sh_load = 1'b1;
          timer_d = '0;
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        // Button edges win over a same-cycle digit, which wins over timeout.
        if (alarm_edge || time_edge) begin
          if (alarm_edge && time_edge) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
          end else if (value_ok) begin
            state_d = alarm_edge ? ST_COMMIT_A : ST_COMMIT_C;
          end else begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
          end
        end else if (digit_ok) begin
          sh_shift = 1'b1;
          timer_d  = '0;
        end else if (one_second) begin
          if (timer_q == TMR_LAST) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
          end else begin
            timer_d = timer_q + TMR_W'(1);
          end
        end
      end
      ST_COMMIT_A, ST_COMMIT_C: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the registered state, so the strobe follows the
  // commit state by one cycle while the frozen buffer keeps the bus stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      alarm_d_q <= 1'b0;
      time_d_q  <= 1'b0;
      load_a_q  <= 1'b0;
      load_c_q  <= 1'b0;
      show_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      alarm_d_q <= alarm_button;
      time_d_q  <= time_button;
      load_a_q  <= (state_q == ST_COMMIT_A);
      load_c_q  <= (state_q == ST_COMMIT_C);
      show_q    <= (state_q == ST_ENTRY);
    end
  end

  aclk_key_shreg u_shreg (
    .clk       (clk),
    .reset     (reset),
    .load_i    (sh_load),
    .shift_i   (sh_shift),
    .cnt_clr_i (cnt_clr),
    .key_i     (key),
    .ms_hr_o   (ms_hr),
    .ls_hr_o   (ls_hr),
    .ms_min_o  (ms_min),
    .ls_min_o  (ls_min),
    .count_o   (count)
  );

  assign new_alarm_ms_hr  = ms_hr;
  assign new_alarm_ls_hr  = ls_hr;
  assign new_alarm_ms_min = ms_min;
  assign new_alarm_ls_min = ls_min;
  assign digit_count      = count;
  assign load_new_a       = load_a_q;
  assign load_new_c       = load_c_q;
  assign show_new_time    = show_q;

endmodule

// File: tb/tb_aclk_key_entry.sv
// Directed bench for aclk_key_entry: a queue-based model of the entry rules
// checked every cycle, plus literal expectations for each scenario.
module tb_aclk_key_entry;

  localparam int TIMEOUT = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic [3:0] key = 4'd0;
  logic       key_valid = 1'b0;
  logic       alarm_button = 1'b0;
  logic       time_button = 1'b0;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       load_a, load_c, show;
  logic [2:0] dcount;

  int n_cmp = 0;
  int n_bad = 0;

  aclk_key_entry #(.TIMEOUT_SEC(TIMEOUT), .TMR_W(4)) dut (
    .clk(clk), .reset(reset), .one_second(one_second), .key(key),
    .key_valid(key_valid), .alarm_button(alarm_button), .time_button(time_button),
    .new_alarm_ms_hr(ms_hr), .new_alarm_ls_hr(ls_hr),
    .new_alarm_ms_min(ms_min), .new_alarm_ls_min(ls_min),
    .load_new_a(load_a), .load_new_c(load_c),
    .show_new_time(show), .digit_count(dcount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 entering, 2 alarm accepted, 3 time accepted.
  int m_mode, m_cnt, m_secs;
  int m_q[$];
  bit m_pa, m_pt;
  bit e_la, e_lc, e_show;

  function automatic bit m_valid();
    int hh, mm;
    hh = m_q[0] * 10 + m_q[1];
    mm = m_q[2] * 10 + m_q[3];
    return (m_cnt == 4) && (hh < 24) && (mm < 60);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_secs = 0; m_q = '{0, 0, 0, 0};
      m_pa = 0; m_pt = 0; e_la = 0; e_lc = 0; e_show = 0;
    end else begin
      bit ae, te, dig;
      ae = alarm_button && !m_pa;
      te = time_button && !m_pt;
      dig = key_valid && (key < 10);
      m_pa = alarm_button;
      m_pt = time_button;
      e_la = (m_mode == 2);
      e_lc = (m_mode == 3);
      e_show = (m_mode == 1);
      case (m_mode)
        0: if (dig) begin
          m_q = '{0, 0, 0, int'(key)}; m_cnt = 1; m_secs = 0; m_mode = 1;
        end
        1: begin
          if (ae || te) begin
            if (!(ae && te) && m_valid()) m_mode = ae ? 2 : 3;
            else begin m_mode = 0; m_cnt = 0; end
          end else if (dig) begin
            m_q.push_back(int'(key));
            m_q.delete(0);
            if (m_cnt < 4) m_cnt++;
            m_secs = 0;
          end else if (one_second) begin
            m_secs++;
            if (m_secs == TIMEOUT) begin m_mode = 0; m_cnt = 0; end
          end
        end
        default: begin m_mode = 0; m_cnt = 0; end
      endcase
    end
  end

  int pulses_a = 0, pulses_c = 0;
  int cap[4];

  always @(negedge clk) begin
    chk("ms_hr", ms_hr, m_q[0]);
    chk("ls_hr", ls_hr, m_q[1]);
    chk("ms_min", ms_min, m_q[2]);
    chk("ls_min", ls_min, m_q[3]);
    chk("digit_count", dcount, m_cnt);
    chk("load_new_a", load_a, e_la);
    chk("load_new_c", load_c, e_lc);
    chk("show_new_time", show, e_show);
    if (load_a) pulses_a++;
    if (load_c) pulses_c++;
    if (load_a || load_c) cap = '{ms_hr, ls_hr, ms_min, ls_min};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int k);
    key = 4'(k); key_valid = 1'b1;
    tick();
    key_valid = 1'b0; key = 4'd0;
  endtask

  task automatic press_btn(input bit a, input bit t);
    alarm_button = a; time_button = t;
    tick();
    alarm_button = 1'b0; time_button = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic sec();
    one_second = 1'b1;
    tick();
    one_second = 1'b0;
  endtask

  task automatic keys4(input int a, input int b, input int c, input int d);
    press_key(a); press_key(b); press_key(c); press_key(d);
  endtask

  int pa0, pc0;

  initial begin
    #23;
    chk("reset_count", dcount, 0);
    chk("reset_show", show, 0);
    chk("reset_load_a", load_a, 0);
    reset = 1'b0;
    tick();

    // 12:34 to alarm, with exact strobe latency
    keys4(1, 2, 3, 4);
    chk("t1_count", dcount, 4);
    chk("t1_show", show, 1);
    pa0 = pulses_a; pc0 = pulses_c;
    alarm_button = 1'b1;
    tick();
    chk("t1_no_strobe_yet", load_a, 0);
    alarm_button = 1'b0;
    tick();
    chk("t1_strobe", load_a, 1);
    chk("t1_load_c", load_c, 0);
    chk("t1_digits", {ms_hr, ls_hr, ms_min, ls_min}, 16'h1234);
    tick();
    chk("t1_strobe_end", load_a, 0);
    chk("t1_show_off", show, 0);
    chk("t1_pulses", pulses_a - pa0, 1);
    chk("t1_digits_held", {ms_hr, ls_hr, ms_min, ls_min}, 16'h1234);

    // 10:45 to time counter
    pa0 = pulses_a; pc0 = pulses_c;
    keys4(1, 0, 4, 5);
    press_btn(1'b0, 1'b1);
    chk("t2_pulses_c", pulses_c - pc0, 1);
    chk("t2_pulses_a", pulses_a - pa0, 0);
    chk("t2_cap", cap[0] * 1000 + cap[1] * 100 + cap[2] * 10 + cap[3], 1045);

    // 25:00 invalid, 23:59 valid, 12:60 invalid
    pa0 = pulses_a;
    keys4(2, 5, 0, 0); press_btn(1'b1, 1'b0);
    chk("t3_2500_pulses", pulses_a - pa0, 0);
    chk("t3_2500_count", dcount, 0);
    keys4(2, 3, 5, 9); press_btn(1'b1, 1'b0);
    chk("t3_2359_pulses", pulses_a - pa0, 1);
    chk("t3_2359_cap", cap[0] * 1000 + cap[1] * 100 + cap[2] * 10 + cap[3], 2359);
    keys4(1, 2, 6, 0); press_btn(1'b1, 1'b0);
    chk("t3_1260_pulses", pulses_a - pa0, 1);

    // five digits with a non-digit key in the middle, then both buttons
    pa0 = pulses_a; pc0 = pulses_c;
    press_key(7); press_key(1); press_key(12); press_key(2); press_key(3); press_key(0);
    chk("t4_digits", {ms_hr, ls_hr, ms_min, ls_min}, 16'h1230);
    chk("t4_count", dcount, 4);
    press_btn(1'b1, 1'b1);
    chk("t4_conflict", (pulses_a - pa0) + (pulses_c - pc0), 0);
    chk("t4_count_cleared", dcount, 0);
    chk("t4_show", show, 0);

    // inactivity timeout
    press_key(5);
    repeat (9) sec();
    chk("t5_still_entry", show, 1);
    sec();
    chk("t5_timeout_count", dcount, 0);
    tick();
    chk("t5_show_off", show, 0);
    chk("t5_buffer_kept", ls_min, 5);

    // digit with the 9th tick restarts the timer; alarm with count 2 ignored
    pa0 = pulses_a;
    press_key(5);
    repeat (8) sec();
    key = 4'd6; key_valid = 1'b1; one_second = 1'b1;
    tick();
    key_valid = 1'b0; one_second = 1'b0;
    repeat (9) sec();
    chk("t5_restart_show", show, 1);
    chk("t5_restart_count", dcount, 2);
    press_btn(1'b1, 1'b0);
    chk("t5_cnt2_pulses", pulses_a - pa0, 0);
    chk("t5_cnt2_count", dcount, 0);

    // reset in ENTRY
    keys4(1, 1, 1, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_entry_show", show, 0);
    chk("t6_rst_entry_count", dcount, 0);
    chk("t6_rst_entry_digit", ls_min, 0);
    tick();
    reset = 1'b0;
    tick();

    // reset while in the commit state: strobe never appears
    pa0 = pulses_a;
    keys4(1, 1, 1, 1);
    alarm_button = 1'b1;
    tick();
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_commit_la", load_a, 0);
    tick();
    tick();
    // alarm still held across reset release must not count as a press
    reset = 1'b0;
    tick();
    keys4(1, 1, 1, 1);
    repeat (4) tick();
    alarm_button = 1'b0;
    tick();
    chk("t6_no_strobe", pulses_a - pa0, 0);
    chk("t6_still_entry", show, 1);

    // reset during the strobe cycle itself
    pa0 = pulses_a;
    alarm_button = 1'b1;
    tick();
    alarm_button = 1'b0;
    tick();
    chk("t6_strobe_up", load_a, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_strobe_cut", load_a, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("t6_single_pulse", pulses_a - pa0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
